// File: rtl/bcd_stopwatch.sv
// MM:SS stopwatch with BCD digit counters, up/down modes, a validated preset load and a rotating snake LED.
// The optional lap-hold display freeze is compiled in with `define BCD_STOPWATCH_LAP_EN.
module bcd_stopwatch #(
  parameter int SEC_MOD = 60,
  parameter int MIN_MOD = 60,
  parameter int SNAKE_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               start_stop,
  input  logic               clear,
  input  logic               mode,
  input  logic               load_valid,
  input  logic [7:0]         load_min,
  input  logic [7:0]         load_sec,
  input  logic               lap,
  output logic [7:0]         disp_min,
  output logic [7:0]         disp_sec,
  output logic               running,
  output logic               expired,
  output logic               load_err,
  output logic               min_wrap,
  output logic [SNAKE_W-1:0] snake
);

  localparam logic [7:0] SEC_MAX = 8'((((SEC_MOD - 1) / 10) << 4) + ((SEC_MOD - 1) % 10));
  localparam logic [7:0] MIN_MAX = 8'((((MIN_MOD - 1) / 10) << 4) + ((MIN_MOD - 1) % 10));

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_e;

  state_e state_q, state_d;

  logic [7:0]         sec_q, sec_d, min_q, min_d;
  logic [SNAKE_W-1:0] snake_q, snake_d;
  logic               wrap_q, wrap_d, lerr_q, lerr_d;

  logic [1:0] sync_q, fill_q;
  logic       ss_prev_q, armed_q;
  logic       start_stop_edge, edge_eff, pause_ev;

  logic [7:0] sec_nx, min_nx;
  logic       wrap_nx, count_tick, cnt_zero, nx_zero;
  logic       load_fmt_ok, load_acc, load_rej;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    return (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Button synchroniser; edges are only armed once the chain has seen the button low after reset,
  // so a button held through reset release never looks like a press. Clear leaves this untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b00;
      ss_prev_q <= 1'b0;
      fill_q    <= 2'b00;
      armed_q   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], start_stop};
      ss_prev_q <= sync_q[1];
      fill_q    <= {fill_q[0], 1'b1};
      if (fill_q[1] && !sync_q[1]) armed_q <= 1'b1;
    end
  end

  assign start_stop_edge = armed_q & sync_q[1] & ~ss_prev_q;
  assign edge_eff        = start_stop_edge & ~clear & ~load_valid;
  assign pause_ev        = (state_q == RUN) & edge_eff;

  // BCD digits compare numerically once each digit is known to be <= 9.
  assign load_fmt_ok = (load_sec[3:0] <= 4'd9) && (load_sec[7:4] <= 4'd9) &&
                       (load_min[3:0] <= 4'd9) && (load_min[7:4] <= 4'd9) &&
                       (load_sec <= SEC_MAX) && (load_min <= MIN_MAX);
  assign load_acc    = load_valid && !clear && load_fmt_ok &&
                       ((state_q == IDLE) || (state_q == PAUSE));
  assign load_rej    = load_valid && !clear && !load_acc;

  assign count_tick = (state_q == RUN) && tick;
  assign cnt_zero   = (sec_q == 8'h00) && (min_q == 8'h00);
  assign nx_zero    = (sec_nx == 8'h00) && (min_nx == 8'h00);

  always_comb begin
    sec_nx  = sec_q;
    min_nx  = min_q;
    wrap_nx = 1'b0;
    if (!mode) begin
      if (sec_q == SEC_MAX) begin
        sec_nx = 8'h00;
        if (min_q == MIN_MAX) begin
          min_nx  = 8'h00;
          wrap_nx = 1'b1;
        end else begin
          min_nx = bcd_inc(min_q);
        end
      end else begin
        sec_nx = bcd_inc(sec_q);
      end
    end else begin
      if (sec_q == 8'h00) begin
        sec_nx = SEC_MAX;
        min_nx = (min_q == 8'h00) ? MIN_MAX : bcd_dec(min_q);
      end else begin
        sec_nx = bcd_dec(sec_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, PAUSE: if (edge_eff && !(mode && cnt_zero)) state_d = RUN;
        RUN: begin
          if (edge_eff)                     state_d = PAUSE;
          else if (tick && mode && nx_zero) state_d = EXPIRED;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    running = 1'b0;
    expired = 1'b0;
    case (state_q)
      RUN:     running = 1'b1;
      EXPIRED: expired = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    sec_d   = sec_q;
    min_d   = min_q;
    snake_d = snake_q;
    wrap_d  = 1'b0;
    lerr_d  = load_rej;
    if (clear) begin
      sec_d   = 8'h00;
      min_d   = 8'h00;
      snake_d = SNAKE_W'(1);
      lerr_d  = 1'b0;
    end else if (load_acc) begin
      sec_d = load_sec;
      min_d = load_min;
    end else if (count_tick) begin
      sec_d   = sec_nx;
      min_d   = min_nx;
      wrap_d  = wrap_nx;
      snake_d = {snake_q[SNAKE_W-2:0], snake_q[SNAKE_W-1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_q   <= 8'h00;
      min_q   <= 8'h00;
      snake_q <= SNAKE_W'(1);
      wrap_q  <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      sec_q   <= sec_d;
      min_q   <= min_d;
      snake_q <= snake_d;
      wrap_q  <= wrap_d;
      lerr_q  <= lerr_d;
    end
  end

  assign snake    = snake_q;
  assign min_wrap = wrap_q;
  assign load_err = lerr_q;

`ifdef BCD_STOPWATCH_LAP_EN
  logic       hold_q, hold_d;
  logic [7:0] lap_min_q, lap_min_d, lap_sec_q, lap_sec_d;

  // Freeze captures the pre-tick count; any lap, pause or clear releases it.
  always_comb begin
    hold_d    = hold_q;
    lap_min_d = lap_min_q;
    lap_sec_d = lap_sec_q;
    if (clear) begin
      hold_d = 1'b0;
    end else if (hold_q) begin
      if (lap || pause_ev) hold_d = 1'b0;
    end else if (lap && (state_q == RUN) && !pause_ev) begin
      hold_d    = 1'b1;
      lap_min_d = min_q;
      lap_sec_d = sec_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= 1'b0;
      lap_min_q <= 8'h00;
      lap_sec_q <= 8'h00;
    end else begin
      hold_q    <= hold_d;
      lap_min_q <= lap_min_d;
      lap_sec_q <= lap_sec_d;
    end
  end

  assign disp_min = hold_q ? lap_min_q : min_q;
  assign disp_sec = hold_q ? lap_sec_q : sec_q;
`else
  logic unused_lap;
  assign unused_lap = lap ^ pause_ev;
  assign disp_min   = min_q;
  assign disp_sec   = sec_q;
`endif

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Self-checking bench for bcd_stopwatch (SEC_MOD=60, MIN_MOD=60, SNAKE_W=8): load vector table with
// scoreboard queue, plus hand sequences for wrap, expiry, same-cycle priority and lap hold.
module tb_bcd_stopwatch;

  logic       clk = 1'b0;
  logic       rst_n, tick, start_stop, clear, mode, load_valid, lap;
  logic [7:0] load_min, load_sec, disp_min, disp_sec, snake;
  logic       running, expired, load_err, min_wrap;

  int n_checks = 0;
  int n_fail   = 0;
  int t;
  logic [7:0] sm;

  typedef struct {
    logic [7:0]  lmin;
    logic [7:0]  lsec;
    logic        exp_err;
    logic [15:0] exp_disp;
  } vec_t;

  typedef struct {
    logic        exp_err;
    logic [15:0] exp_disp;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];

  always #5 clk = ~clk;

  bcd_stopwatch #(.SEC_MOD(60), .MIN_MOD(60), .SNAKE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start_stop(start_stop), .clear(clear),
    .mode(mode), .load_valid(load_valid), .load_min(load_min), .load_sec(load_sec),
    .lap(lap), .disp_min(disp_min), .disp_sec(disp_sec), .running(running),
    .expired(expired), .load_err(load_err), .min_wrap(min_wrap), .snake(snake)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] bcd16(input int tt);
    int m = tt / 60;
    int s = tt % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press();
    start_stop = 1'b1;
    repeat (3) step();
    start_stop = 1'b0;
    repeat (3) step();
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
  endtask

  task automatic model_tick();
    if (!mode) t = (t + 1) % 3600;
    else       t = (t == 0) ? 3599 : t - 1;
    sm = {sm[6:0], sm[7]};
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    t  = 0;
    sm = 8'h01;
  endtask

  task automatic do_load(input logic [7:0] m, input logic [7:0] s);
    load_min   = m;
    load_sec   = s;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    vecs[0] = '{8'h12, 8'h34, 1'b0, 16'h1234};
    vecs[1] = '{8'h00, 8'h60, 1'b1, 16'h1234};
    vecs[2] = '{8'h0A, 8'h00, 1'b1, 16'h1234};
    vecs[3] = '{8'h60, 8'h00, 1'b1, 16'h1234};
    vecs[4] = '{8'h00, 8'h5F, 1'b1, 16'h1234};
    vecs[5] = '{8'h59, 8'h59, 1'b0, 16'h5959};

    rst_n = 1'b1; tick = 1'b0; start_stop = 1'b1; clear = 1'b0; mode = 1'b0;
    load_valid = 1'b0; lap = 1'b0; load_min = 8'h00; load_sec = 8'h00;
    #3 rst_n = 1'b0;
    #20;
    check("rst_disp", {disp_min, disp_sec}, 16'h0000);
    check("rst_snake", snake, 8'h01);
    check("rst_flags", {running, expired, load_err, min_wrap}, 4'b0000);
    @(negedge clk) rst_n = 1'b1;
    repeat (6) step();
    check("held_button_no_start", running, 1'b0);
    start_stop = 1'b0;
    repeat (3) step();

    foreach (vecs[i]) begin
      sb.push_back('{vecs[i].exp_err, vecs[i].exp_disp});
      do_load(vecs[i].lmin, vecs[i].lsec);
      e = sb.pop_front();
      check("tbl_load_err", load_err, e.exp_err);
      check("tbl_disp", {disp_min, disp_sec}, e.exp_disp);
      step();
      check("tbl_err_one_cycle", load_err, 1'b0);
    end

    // 59:59 up -> 00:00 with single-cycle min_wrap
    t = 3599; sm = 8'h01;
    press();
    check("run_after_edge", running, 1'b1);
    tick = 1'b1;
    step();
    tick = 1'b0;
    model_tick();
    check("wrap_disp", {disp_min, disp_sec}, bcd16(t));
    check("wrap_pulse", min_wrap, 1'b1);
    check("wrap_snake", snake, sm);
    step();
    check("wrap_pulse_end", min_wrap, 1'b0);

    // 60 ticks from 00:00
    do_clear();
    check("clear_disp", {disp_min, disp_sec}, 16'h0000);
    check("clear_idle", running, 1'b0);
    check("clear_snake", snake, 8'h01);
    press();
    for (int k = 0; k < 60; k++) begin
      do_tick();
      model_tick();
      check("up_disp", {disp_min, disp_sec}, bcd16(t));
    end
    check("up_60_disp", {disp_min, disp_sec}, 16'h0100);
    check("up_60_snake", snake, 8'h10);

    sb.push_back('{1'b1, bcd16(t)});
    do_load(8'h00, 8'h05);
    e = sb.pop_front();
    check("run_load_err", load_err, e.exp_err);
    check("run_load_disp", {disp_min, disp_sec}, e.exp_disp);
    step();
    check("run_load_err_end", load_err, 1'b0);

    // tick coinciding with the pause edge still counts
    start_stop = 1'b1;
    step(); step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    model_tick();
    check("pause_tick_disp", {disp_min, disp_sec}, bcd16(t));
    check("pause_state", running, 1'b0);
    check("pause_tick_snake", snake, sm);
    start_stop = 1'b0;
    repeat (3) step();
    do_tick();
    check("pause_hold_disp", {disp_min, disp_sec}, bcd16(t));
    check("pause_hold_snake", snake, sm);

    // clear + load + edge in one cycle
    start_stop = 1'b1;
    step(); step();
    clear = 1'b1; load_valid = 1'b1; load_min = 8'h00; load_sec = 8'h07;
    step();
    clear = 1'b0; load_valid = 1'b0;
    t = 0; sm = 8'h01;
    check("prio_disp", {disp_min, disp_sec}, 16'h0000);
    check("prio_flags", {running, load_err}, 2'b00);
    check("prio_snake", snake, sm);
    start_stop = 1'b0;
    repeat (3) step();
    check("prio_still_idle", running, 1'b0);

    // down at 00:00 refuses to start
    mode = 1'b1;
    press();
    check("down_zero_no_start", running, 1'b0);

    // down from 00:03 expires
    do_load(8'h00, 8'h03);
    t = 3;
    check("down_load", {disp_min, disp_sec}, 16'h0003);
    press();
    check("down_run", running, 1'b1);
    for (int k = 0; k < 3; k++) begin
      do_tick();
      model_tick();
      check("down_disp", {disp_min, disp_sec}, bcd16(t));
    end
    check("expired_level", {expired, running}, 2'b10);
    press();
    check("expired_ignores_edge", {expired, running}, 2'b10);
    do_tick();
    check("expired_disp", {disp_min, disp_sec}, 16'h0000);
    check("expired_snake", snake, sm);

    // lap hold, mode switch mid-run, release by pause
    do_clear();
    check("clear_from_expired", expired, 1'b0);
    mode = 1'b0;
    do_load(8'h00, 8'h05);
    t = 5;
    press();
    lap = 1'b1;
    step();
    lap = 1'b0;
    for (int k = 0; k < 4; k++) begin
      do_tick();
      model_tick();
    end
`ifdef BCD_STOPWATCH_LAP_EN
    check("lap_frozen", {disp_min, disp_sec}, 16'h0005);
`else
    check("lap_ignored", {disp_min, disp_sec}, 16'h0009);
`endif
    lap = 1'b1;
    step();
    lap = 1'b0;
    check("lap_release", {disp_min, disp_sec}, 16'h0009);
    mode = 1'b1;
    do_tick();
    model_tick();
    check("mode_switch_disp", {disp_min, disp_sec}, bcd16(t));
    lap = 1'b1;
    step();
    lap = 1'b0;
    do_tick();
    model_tick();
`ifdef BCD_STOPWATCH_LAP_EN
    check("lap2_frozen", {disp_min, disp_sec}, 16'h0008);
`else
    check("lap2_ignored", {disp_min, disp_sec}, bcd16(t));
`endif
    press();
    check("pause_releases_lap", {disp_min, disp_sec}, bcd16(t));
    check("lap_paused", running, 1'b0);
    check("lap_snake", snake, sm);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
